// File: rtl/zp_single.sv
// -----------------------------------------------------------------------------
// zp_single
//   Zero-pads a flattened W x H feature map with a border of P zero pixels on
//   every side. The padded map is captured into an output register when
//   in_valid is high, so the result appears exactly one clock later. The
//   output map holds its value between loads and one map is accepted per
//   clock.
//
// Parameters
//   W, H        input map width / height in pixels
//   DATA_WIDTH  bits per pixel
//   P           border thickness in pixels (0 makes this a plain register)
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset (clears Out_map and out_valid)
//   in_valid   capture request for In_map
//   In_map     input map, row-major, pixel 0 in the most significant slot
//   out_valid  high for one cycle after each accepted map
//   Out_map    padded map, row-major, pixel 0 in the most significant slot
// -----------------------------------------------------------------------------
module zp_single #(
    parameter int W          = 32,
    parameter int H          = 32,
    parameter int DATA_WIDTH = 8,
    parameter int P          = 1
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          in_valid,
    input  logic [W*H*DATA_WIDTH-1:0]                     In_map,
    output logic                                          out_valid,
    output logic [(W+2*P)*(H+2*P)*DATA_WIDTH-1:0]         Out_map
);

    localparam int OW     = W + 2*P;
    localparam int OH     = H + 2*P;
    localparam int IN_PX  = W * H;
    localparam int OUT_PX = OW * OH;

    logic [OUT_PX*DATA_WIDTH-1:0] padded_s;
    logic [OUT_PX*DATA_WIDTH-1:0] out_map_r;
    logic                         out_valid_r;

    // The padding pattern is fixed at elaboration, so each output slot is
    // either a straight wire from one input pixel or a constant zero; no
    // muxing is involved.
    for (genvar r = 0; r < OH; r++) begin : g_row
        for (genvar c = 0; c < OW; c++) begin : g_col
            if ((r >= P) && (r < H + P) && (c >= P) && (c < W + P)) begin : g_pix
                assign padded_s[DATA_WIDTH*(OUT_PX-1-(r*OW+c)) +: DATA_WIDTH] =
                    In_map[DATA_WIDTH*(IN_PX-1-((r-P)*W+(c-P))) +: DATA_WIDTH];
            end else begin : g_zero
                assign padded_s[DATA_WIDTH*(OUT_PX-1-(r*OW+c)) +: DATA_WIDTH] =
                    {DATA_WIDTH{1'b0}};
            end
        end
    end

    // Output register: reset wins over a capture; without a capture the map
    // holds and only the valid flag drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_map_r   <= '0;
            out_valid_r <= 1'b0;
        end else if (in_valid) begin
            out_map_r   <= padded_s;
            out_valid_r <= 1'b1;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign Out_map   = out_map_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_zp_single.sv
// -----------------------------------------------------------------------------
// tb_zp_single
//   Directed bench for zp_single. Three instances share one clock and reset:
//   the default 32x32 / P=1 map, a 2x2 / P=1 map and a 3x2 / P=0 map.
//   Inputs change and outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_zp_single;

    localparam int DEF_IN_PX  = 32 * 32;
    localparam int DEF_OUT_W  = 34;
    localparam int DEF_OUT_PX = 34 * 34;

    logic clk;
    logic rst_n;

    logic                      def_valid_in;
    logic [DEF_IN_PX*8-1:0]    def_in;
    logic                      def_valid_out;
    logic [DEF_OUT_PX*8-1:0]   def_out;

    logic                      sm_valid_in;
    logic [31:0]               sm_in;
    logic                      sm_valid_out;
    logic [127:0]              sm_out;

    logic                      z_valid_in;
    logic [47:0]               z_in;
    logic                      z_valid_out;
    logic [47:0]               z_out;

    int n_compared;
    int n_mismatched;

    zp_single u_def (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (def_valid_in),
        .In_map    (def_in),
        .out_valid (def_valid_out),
        .Out_map   (def_out)
    );

    zp_single #(.W(2), .H(2), .DATA_WIDTH(8), .P(1)) u_small (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (sm_valid_in),
        .In_map    (sm_in),
        .out_valid (sm_valid_out),
        .Out_map   (sm_out)
    );

    zp_single #(.W(3), .H(2), .DATA_WIDTH(8), .P(0)) u_p0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (z_valid_in),
        .In_map    (z_in),
        .out_valid (z_valid_out),
        .Out_map   (z_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] def_px(input int j);
        return def_out[8*(DEF_OUT_PX-1-j) +: 8];
    endfunction

    task automatic test_reset();
        rst_n        = 1'b0;
        def_valid_in = 1'b0;
        sm_valid_in  = 1'b0;
        z_valid_in   = 1'b0;
        tick();
        n_compared++;
        if (def_valid_out !== 1'b0) begin
            n_mismatched++;
            $display("FAIL reset_def_valid got %b want 0", def_valid_out);
        end
        n_compared++;
        if (def_out !== '0) begin
            n_mismatched++;
            $display("FAIL reset_def_map not all zero");
        end
        n_compared++;
        if (sm_valid_out !== 1'b0 || sm_out !== 128'h0) begin
            n_mismatched++;
            $display("FAIL reset_small got valid=%b map=%h want 0/0", sm_valid_out, sm_out);
        end
        n_compared++;
        if (z_valid_out !== 1'b0 || z_out !== 48'h0) begin
            n_mismatched++;
            $display("FAIL reset_p0 got valid=%b map=%h want 0/0", z_valid_out, z_out);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_default_map();
        logic [7:0] exp;
        for (int i = 0; i < DEF_IN_PX; i++) begin
            def_in[8*(DEF_IN_PX-1-i) +: 8] = i[7:0];
        end
        def_valid_in = 1'b1;
        tick();
        def_valid_in = 1'b0;
        n_compared++;
        if (def_valid_out !== 1'b1) begin
            n_mismatched++;
            $display("FAIL def_valid got %b want 1", def_valid_out);
        end
        // Spot checks straight from the worked example.
        n_compared++;
        if (def_px(35) !== 8'h00) begin
            n_mismatched++;
            $display("FAIL def_px35 got %h want 00", def_px(35));
        end
        n_compared++;
        if (def_px(36) !== 8'h01) begin
            n_mismatched++;
            $display("FAIL def_px36 got %h want 01", def_px(36));
        end
        n_compared++;
        if (def_px(34 + 33) !== 8'h00) begin
            n_mismatched++;
            $display("FAIL def_px67 got %h want 00", def_px(34 + 33));
        end
        n_compared++;
        if (def_px(32*DEF_OUT_W + 32) !== 8'hFF) begin
            n_mismatched++;
            $display("FAIL def_px_r32c32 got %h want FF", def_px(32*DEF_OUT_W + 32));
        end
        n_compared++;
        if (def_px(32*DEF_OUT_W + 2) !== 8'hE1) begin
            n_mismatched++;
            $display("FAIL def_px_r32c2 got %h want E1", def_px(32*DEF_OUT_W + 2));
        end
        // Whole map: border zero, interior pixel (r-1)*32+(c-1) mod 256.
        for (int r = 0; r < DEF_OUT_W; r++) begin
            for (int c = 0; c < DEF_OUT_W; c++) begin
                if (r >= 1 && r <= 32 && c >= 1 && c <= 32) begin
                    exp = 8'(((r - 1) * 32 + (c - 1)) % 256);
                end else begin
                    exp = 8'h00;
                end
                n_compared++;
                if (def_px(r*DEF_OUT_W + c) !== exp) begin
                    n_mismatched++;
                    $display("FAIL def_full r=%0d c=%0d got %h want %h",
                             r, c, def_px(r*DEF_OUT_W + c), exp);
                end
            end
        end
        tick();
        n_compared++;
        if (def_valid_out !== 1'b0) begin
            n_mismatched++;
            $display("FAIL def_valid_drop got %b want 0", def_valid_out);
        end
    endtask

    task automatic test_small_map();
        sm_in       = 32'hA1B2C3D4;
        sm_valid_in = 1'b1;
        tick();
        sm_valid_in = 1'b0;
        n_compared++;
        if (sm_valid_out !== 1'b1) begin
            n_mismatched++;
            $display("FAIL small_valid got %b want 1", sm_valid_out);
        end
        n_compared++;
        if (sm_out !== 128'h00000000_00A1B200_00C3D400_00000000) begin
            n_mismatched++;
            $display("FAIL small_map got %h want 00000000_00A1B200_00C3D400_00000000", sm_out);
        end
    endtask

    task automatic test_hold();
        sm_in       = 32'h11223344;
        sm_valid_in = 1'b1;
        tick();
        sm_valid_in = 1'b0;
        sm_in       = 32'hFFFFFFFF;
        n_compared++;
        if (sm_valid_out !== 1'b1 || sm_out !== 128'h00000000_00112200_00334400_00000000) begin
            n_mismatched++;
            $display("FAIL hold_load got valid=%b map=%h", sm_valid_out, sm_out);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_compared++;
            if (sm_valid_out !== 1'b0) begin
                n_mismatched++;
                $display("FAIL hold_valid cycle %0d got %b want 0", k, sm_valid_out);
            end
            n_compared++;
            if (sm_out !== 128'h00000000_00112200_00334400_00000000) begin
                n_mismatched++;
                $display("FAIL hold_map cycle %0d got %h want 00000000_00112200_00334400_00000000",
                         k, sm_out);
            end
        end
    endtask

    task automatic test_reset_priority();
        rst_n       = 1'b0;
        sm_in       = 32'h55667788;
        sm_valid_in = 1'b1;
        tick();
        n_compared++;
        if (sm_valid_out !== 1'b0 || sm_out !== 128'h0) begin
            n_mismatched++;
            $display("FAIL rstprio_clear got valid=%b map=%h want 0/0", sm_valid_out, sm_out);
        end
        rst_n = 1'b1;
        tick();
        sm_valid_in = 1'b0;
        n_compared++;
        if (sm_valid_out !== 1'b1 || sm_out !== 128'h00000000_00556600_00778800_00000000) begin
            n_mismatched++;
            $display("FAIL rstprio_reload got valid=%b map=%h want 1/00000000_00556600_00778800_00000000",
                     sm_valid_out, sm_out);
        end
    endtask

    task automatic test_p0();
        z_in       = 48'h3CA57E01FF90;
        z_valid_in = 1'b1;
        tick();
        z_valid_in = 1'b0;
        z_in       = 48'h123456789ABC;
        n_compared++;
        if (z_valid_out !== 1'b1 || z_out !== 48'h3CA57E01FF90) begin
            n_mismatched++;
            $display("FAIL p0_copy got valid=%b map=%h want 1/3ca57e01ff90", z_valid_out, z_out);
        end
        tick();
        n_compared++;
        if (z_valid_out !== 1'b0 || z_out !== 48'h3CA57E01FF90) begin
            n_mismatched++;
            $display("FAIL p0_hold got valid=%b map=%h want 0/3ca57e01ff90", z_valid_out, z_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0]  maps [3];
        logic [127:0] exps [3];
        maps[0] = 32'h01020304;
        maps[1] = 32'hF0E0D0C0;
        maps[2] = 32'h8000007F;
        exps[0] = 128'h00000000_00010200_00030400_00000000;
        exps[1] = 128'h00000000_00F0E000_00D0C000_00000000;
        exps[2] = 128'h00000000_00800000_00007F00_00000000;
        sm_valid_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sm_in = maps[k];
            tick();
            n_compared++;
            if (sm_valid_out !== 1'b1 || sm_out !== exps[k]) begin
                n_mismatched++;
                $display("FAIL b2b map %0d got valid=%b map=%h want 1/%h",
                         k, sm_valid_out, sm_out, exps[k]);
            end
        end
        sm_valid_in = 1'b0;
        tick();
        n_compared++;
        if (sm_valid_out !== 1'b0 || sm_out !== exps[2]) begin
            n_mismatched++;
            $display("FAIL b2b_end got valid=%b map=%h want 0/%h", sm_valid_out, sm_out, exps[2]);
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst_n        = 1'b0;
        def_valid_in = 1'b0;
        def_in       = '0;
        sm_valid_in  = 1'b0;
        sm_in        = '0;
        z_valid_in   = 1'b0;
        z_in         = '0;
        #1;
        test_reset();
        test_default_map();
        test_small_map();
        test_hold();
        test_reset_priority();
        test_p0();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
